// File: rtl/aes_io_loader_if.sv
// rtl/aes_io_loader_if.sv - load/result bus bundle between the host side and aes_io_loader
interface aes_io_loader_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int REG_W = 128,
    parameter int NCH   = 2,
    parameter int CS_W  = 4
);
    logic [IN_W-1:0]      in;
    logic [CS_W-1:0]      cs;
    logic                 in_valid;
    logic [NCH-1:0]       ch_clr;
    logic [NCH*REG_W-1:0] ch_data;
    logic [NCH-1:0]       ch_full;
    logic                 ovf;
    logic [REG_W-1:0]     res;
    logic                 res_load;
    logic [OUT_W-1:0]     out;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in, cs, in_valid, ch_clr, res, res_load, out_ready,
        output ch_data, ch_full, ovf, out, out_valid
    );

    modport master (
        output in, cs, in_valid, ch_clr, res, res_load, out_ready,
        input  ch_data, ch_full, ovf, out, out_valid
    );
endinterface

// File: rtl/aes_io_loader.sv
// rtl/aes_io_loader.sv - per-channel beat assembler and result serialiser for the AES core
module aes_io_loader #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int REG_W = 128,
    parameter int NCH   = 2,
    parameter int CS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    aes_io_loader_if.slave   bus
);
    localparam int LB = REG_W / IN_W;
    localparam int OB = REG_W / OUT_W;
    localparam int CW = $clog2(LB + 1);
    localparam int RW = $clog2(OB + 1);
    localparam logic [CW-1:0] LB_C = CW'(LB);
    localparam logic [RW-1:0] OB_C = RW'(OB);

    logic [REG_W-1:0] regs [NCH];
    logic [CW-1:0]    cnt  [NCH];
    logic [REG_W-1:0] shifter;
    logic [RW-1:0]    rem;
    logic             ovf_q;

    logic cs_hit;
    logic sel_full;
    logic sel_clr;

    // Decode the addressed channel once so ovf never indexes past NCH.
    always_comb begin
        cs_hit   = 1'b0;
        sel_full = 1'b0;
        sel_clr  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.cs == CS_W'(c)) begin
                cs_hit   = 1'b1;
                sel_full = (cnt[c] == LB_C);
                sel_clr  = bus.ch_clr[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                regs[c] <= '0;
                cnt[c]  <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.ch_clr[c]) begin
                    regs[c] <= '0;
                    cnt[c]  <= '0;
                end else if (bus.in_valid && bus.cs == CS_W'(c) && cnt[c] != LB_C) begin
                    regs[c] <= {regs[c][REG_W-IN_W-1:0], bus.in};
                    cnt[c]  <= cnt[c] + CW'(1);
                end
            end
            // A clear on the targeted channel swallows the beat silently.
            ovf_q <= bus.in_valid && (!cs_hit || (sel_full && !sel_clr));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter <= '0;
            rem     <= '0;
        end else if (bus.res_load) begin
            shifter <= bus.res;
            rem     <= OB_C;
        end else if (rem != '0 && bus.out_ready) begin
            shifter <= shifter << OUT_W;
            rem     <= rem - RW'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign bus.ch_data[g*REG_W +: REG_W] = regs[g];
        assign bus.ch_full[g]                = (cnt[g] == LB_C);
    end

    assign bus.ovf       = ovf_q;
    assign bus.out       = shifter[REG_W-1 -: OUT_W];
    assign bus.out_valid = (rem != '0);
endmodule

// File: tb/tb_aes_io_loader.sv
// tb/tb_aes_io_loader.sv - directed and random checks of aes_io_loader against a queue model
module tb_aes_io_loader;
    localparam int IN_W  = 4;
    localparam int OUT_W = 8;
    localparam int REG_W = 128;
    localparam int NCH   = 2;
    localparam int CS_W  = 4;
    localparam int LB    = REG_W / IN_W;
    localparam int OB    = REG_W / OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_io_loader_if #(.IN_W(IN_W), .OUT_W(OUT_W), .REG_W(REG_W), .NCH(NCH), .CS_W(CS_W)) bus ();

    aes_io_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .REG_W(REG_W), .NCH(NCH), .CS_W(CS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int         q [NCH][$];
    logic [7:0] oq [$];
    logic       exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] model_data(input int c);
        logic [REG_W-1:0] d;
        d = '0;
        foreach (q[c][i]) d = d * (2 ** IN_W) + REG_W'(q[c][i]);
        return d;
    endfunction

    task automatic check_all(input string tag);
        logic [NCH*REG_W-1:0] ed;
        logic [NCH-1:0]       ef;
        for (int c = 0; c < NCH; c++) begin
            ed[c*REG_W +: REG_W] = model_data(c);
            ef[c]                = (q[c].size() == LB);
        end
        chk({tag, ".ch_data"}, bus.ch_data, ed);
        chk({tag, ".ch_full"}, bus.ch_full, ef);
        chk({tag, ".ovf"}, bus.ovf, exp_ovf);
        chk({tag, ".out_valid"}, bus.out_valid, oq.size() != 0);
        chk({tag, ".out"}, bus.out, (oq.size() != 0) ? oq[0] : 8'h00);
    endtask

    task automatic model_step();
        int  tgt;
        bit  push;
        exp_ovf = 1'b0;
        push    = 1'b0;
        tgt     = int'(bus.cs);
        if (bus.in_valid) begin
            if (tgt >= NCH) exp_ovf = 1'b1;
            else if (!bus.ch_clr[tgt]) begin
                if (q[tgt].size() < LB) push = 1'b1;
                else exp_ovf = 1'b1;
            end
        end
        for (int c = 0; c < NCH; c++) if (bus.ch_clr[c]) q[c].delete();
        if (push) q[tgt].push_back(int'(bus.in));
        if (bus.res_load) begin
            oq.delete();
            for (int i = 0; i < OB; i++) oq.push_back(bus.res[REG_W-1-8*i -: 8]);
        end else if (oq.size() != 0 && bus.out_ready) begin
            void'(oq.pop_front());
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.in        = '0;
        bus.cs        = '0;
        bus.in_valid  = 1'b0;
        bus.ch_clr    = '0;
        bus.res       = '0;
        bus.res_load  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic beat(input int c, input int v, input string tag);
        bus.in_valid = 1'b1;
        bus.cs       = CS_W'(c);
        bus.in       = IN_W'(v);
        tick(tag);
        bus.in_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) q[c].delete();
        oq.delete();
        exp_ovf = 1'b0;
    endtask

    logic [REG_W-1:0] snap;
    int               guard;
    int               acc;

    initial begin
        idle();
        #2;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick("post_reset");

        for (int i = 0; i < LB; i++) begin
            beat(0, i % 16, "fill0");
            if (i == LB - 2) chk("full_not_early", bus.ch_full, 2'b00);
        end
        chk("fill0_value", bus.ch_data[127:0], 128'h0123456789ABCDEF0123456789ABCDEF);
        chk("fill0_full", bus.ch_full, 2'b01);

        snap = bus.ch_data[127:0];
        beat(0, 4'hA, "ovf_full");
        chk("ovf_full_pulse", bus.ovf, 1'b1);
        chk("ovf_full_data", bus.ch_data[127:0], snap);
        tick("ovf_full_after");
        chk("ovf_full_gone", bus.ovf, 1'b0);
        beat(5, 4'h3, "ovf_cs5");
        chk("ovf_cs5_pulse", bus.ovf, 1'b1);
        beat(5, 4'h4, "ovf_b2b");
        chk("ovf_b2b_pulse", bus.ovf, 1'b1);
        tick("ovf_cs5_after");

        bus.ch_clr = 2'b01;
        tick("clr0");
        bus.ch_clr = '0;
        chk("clr0_full", bus.ch_full, 2'b00);
        for (int i = 0; i < 32; i++) beat(i % 2, $urandom_range(0, 15), "interleave");
        chk("interleave_full", bus.ch_full, 2'b00);
        snap = bus.ch_data[127:0];
        bus.ch_clr = 2'b10;
        beat(1, 4'h7, "clr_wins");
        bus.ch_clr = '0;
        chk("clr_wins_ch1", bus.ch_data[255:128], 128'h0);
        chk("clr_wins_ch0", bus.ch_data[127:0], snap);
        chk("clr_wins_ovf", bus.ovf, 1'b0);
        beat(1, 4'h9, "ch1_restart");
        chk("ch1_restart_val", bus.ch_data[255:128], 128'h9);

        bus.res      = 128'h00112233445566778899AABBCCDDEEFF;
        bus.res_load = 1'b1;
        tick("res_load");
        bus.res_load = 1'b0;
        chk("first_beat", bus.out, 8'h00);
        bus.out_ready = 1'b1;
        for (int i = 0; i < OB; i++) begin
            chk("drain_seq", bus.out, 8'(8'h11 * i));
            tick("drain");
        end
        chk("drain_done", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        bus.res      = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        bus.res_load = 1'b1;
        tick("res_load2");
        bus.res_load = 1'b0;
        guard = 0;
        acc   = 0;
        while (oq.size() != 0 && guard < 200) begin
            bus.out_ready = (guard % 3 == 0);
            if (bus.out_ready) acc++;
            if (acc == 6 && bus.out_ready) begin
                bus.res      = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
                bus.res_load = 1'b1;
            end
            tick("stall_drain");
            bus.res_load = 1'b0;
            guard++;
        end
        chk("stall_drain_bound", guard < 200, 1'b1);
        bus.out_ready = 1'b0;

        for (int i = 0; i < 10; i++) beat(0, i, "preload");
        bus.res      = {4{32'hDEADBEEF}};
        bus.res_load = 1'b1;
        tick("pre_rst_load");
        bus.res_load  = 1'b0;
        bus.out_ready = 1'b1;
        tick("pre_rst_drain");
        bus.in_valid = 1'b1;
        bus.cs       = '0;
        bus.in       = 4'h5;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid_outvalid", bus.out_valid, 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        beat(0, 4'hC, "after_rst");
        chk("after_rst_cnt0", bus.ch_data[127:0], 128'hC);

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.cs        = CS_W'($urandom_range(0, 3));
            bus.in        = IN_W'($urandom_range(0, 15));
            bus.ch_clr    = NCH'(($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0);
            bus.res_load  = ($urandom_range(0, 24) == 0);
            bus.res       = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = $urandom_range(0, 1);
            tick("random");
        end
        idle();
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_io_loader.md
# aes_io_loader

Parametrised serial I/O front end for the AES datapath; successor to the nibble-at-a-time key/text loader. It assembles NCH wide operand registers (channel 0 = key, 1 = plaintext, further channels spare) from IN_W-bit input beats, with per-channel beat counting, full flags, clear and overflow reporting. It also serialises a REG_W-bit result from the cipher core onto an OUT_W-bit output using a valid/ready handshake. It sits between the board-level switches/host interface and the encrypt core.

## Interface
- IN_W, 4: input beat width; REG_W must be a multiple of IN_W.
- OUT_W, 8: output beat width; REG_W must be a multiple of OUT_W.
- REG_W, 128: operand and result register width.
- NCH, 2: number of load channels, NCH ≥ 1.
- CS_W, 4: width of the channel select; 2^CS_W ≥ NCH.
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in, in, IN_W: input beat.
- cs, in, CS_W: channel select for the current beat; values ≥ NCH address nothing.
- in_valid, in, 1: `in` is valid this cycle.
- ch_clr, in, NCH: per-channel clear request.
- ch_data, out, NCH*REG_W: channel c occupies bits [c*REG_W +: REG_W].
- ch_full, out, NCH: channel c holds REG_W/IN_W beats.
- ovf, out, 1: one-cycle pulse when a beat is dropped.
- res, in, REG_W: result word from the cipher core.
- res_load, in, 1: capture `res` into the output shifter.
- out, out, OUT_W: current output beat, most significant first.
- out_valid, out, 1: `out` holds an unsent beat.
- out_ready, in, 1: consumer accepts `out` this cycle.

## Operation
- Define LB = REG_W/IN_W and OB = REG_W/OUT_W.
- Each channel has a data register and a beat counter cnt_c, 0..LB.
- cnt_c is clog2(LB+1) bits wide.
- The output side has a shift register and a remaining-beat counter rem, 0..OB.
- Reset (async, takes effect immediately): all ch_data = 0, all cnt_c = 0, ch_full = 0, ovf = 0, output shifter = 0, rem = 0, out_valid = 0, out = 0.
- Load, when in_valid=1, cs=c<NCH and cnt_c<LB:
  - reg_c <= {reg_c[REG_W-IN_W-1:0], in}; cnt_c <= cnt_c+1.
  - The first beat therefore ends in the MSBs after LB beats.
- Overflow, when in_valid=1 and either cnt_cs=LB or cs≥NCH:
  - The beat is dropped and no register changes.
  - ovf=1 for the following cycle only.
- ch_clr[c]=1: reg_c <= 0, cnt_c <= 0.
  - If a load targets c in the same cycle, clear wins: the beat is discarded and no ovf is raised.
  - Clears on other channels are independent of the load.
- ch_full[c] = (cnt_c == LB), taken from registered state.
- Output capture, res_load=1: shifter <= res, rem <= OB.
  - Any beats still in flight are abandoned.
  - res_load takes priority over out_ready in the same cycle.
- Output transfer, when out_valid=1 and out_ready=1 with no res_load:
  - shifter <= shifter << OUT_W; rem <= rem-1.
- out = shifter[REG_W-1 -: OUT_W]; out_valid = (rem != 0).
- out_ready while out_valid=0 has no effect.
- The load side and output side are fully independent and operate concurrently.

## Timing
- Load latency is 1 cycle: ch_data and ch_full reflect a beat on the edge that accepts it.
- ch_full rises on the edge accepting beat LB.
- ovf asserts on the edge after the dropped beat and is high for exactly one cycle.
- Back-to-back ovf events give back-to-back pulses.
- Clear latency is 1 cycle; ch_full drops on that edge.
- Output latency is 1 cycle from res_load to out_valid=1 with out = res[REG_W-1 -: OUT_W].
- A full result drains in OB cycles when out_ready is held high.
- out_valid falls on the edge accepting the last beat.
- out and out_valid are held stable while out_valid=1 and out_ready=0.
- Reset mid-load or mid-drain discards all partial state; the first edge after rst deasserts behaves as post-reset.

## Test plan
- Reset, then 32 beats on cs=0 with in=0x0..0xF repeating:
  - ch_data[127:0] = 0x0123456789ABCDEF0123456789ABCDEF.
  - ch_full = 2'b01 after the 32nd edge, not before.
- With channel 0 full, one more beat in=0xA:
  - ch_data unchanged; ovf high for exactly one cycle.
  - A beat with cs=5 also yields one ovf pulse.
- Interleave cs=0 and cs=1 beats, 16 each:
  - Both counters read 16 with ch_full=0.
  - ch_clr=2'b10 plus a cs=1 beat in the same cycle: channel 1 = 0 with cnt 0, channel 0 untouched, no ovf.
- res_load with res=0x00112233445566778899AABBCCDDEEFF, out_ready high:
  - out sequence is 0x00, 0x11, …, 0xFF over 16 cycles; out_valid low after the 16th.
- Same drain with out_ready toggled 1,0,0,1,…:
  - Beats held stable during stalls; no loss or duplication.
  - res_load mid-drain restarts from the new word's MSB.
- Assert rst asynchronously mid-load and mid-drain:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The next load starts at cnt=0.
